res_mem_arbiter: RTL

//  Shares the single-port 16K x 8 result memory (res_*) among NREQ engines: image loader, forward/backward DT pass, host readback.

---
 rtl/dt_pkg.sv | 15 +
 rtl/rr_pick.sv | 35 +++
 rtl/res_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// Shared definitions for the DT datapath: image geometry, result-memory shape
// and the arbiter state encoding.
package dt_pkg;

    localparam int unsigned IMG_W  = 128;
    localparam int unsigned IMG_H  = 128;
    localparam int unsigned RES_AW = $clog2(IMG_W * IMG_H);
    localparam int unsigned RES_DW = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first set request at or after ptr_i wins.
// The picker is purely combinational.
module rr_pick #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         onehot_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int unsigned IW = $clog2(NREQ);

    int unsigned     cand;
    logic [IW-1:0]   cand_idx;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(ptr_i) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o    = 1'b1;
                idx_o    = cand_idx;
                onehot_o = NREQ'(1) << cand_idx;
            end
        end
    end

endmodule

// File: rtl/res_mem_arbiter.sv
// Round-robin arbiter for the single-port result memory, with bounded lock
// bursts, a registered command stage (T+1) and a tagged read return (T+2).
module res_mem_arbiter
    import dt_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = RES_AW,
    parameter int unsigned DW       = RES_DW,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rvalid,
    output logic [DW-1:0]           rdata,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    res_rd,
    output logic                    res_wr,
    output logic [AW-1:0]           res_addr,
    output logic [DW-1:0]           res_do,
    input  logic [DW-1:0]           res_di
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    arb_state_t      state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   owner_q;
    logic [HW-1:0]   hold_q;

    logic [NREQ-1:0] pick_req;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [NREQ-1:0] others;
    logic            use_pick;
    logic            own_gnt;
    logic            preempt;
    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (pick_req),
        .ptr_i    (pick_ptr),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    // In LOCK the shared picker is reused to pick a preempting requester,
    // scanning from the requester just after the owner.
    always_comb begin
        others   = req & ~(NREQ'(1) << owner_q);
        pick_req = req;
        pick_ptr = ptr_q;
        use_pick = 1'b1;
        own_gnt  = 1'b0;
        preempt  = 1'b0;
        if (state_q == LOCK) begin
            if (!req[owner_q]) begin
                use_pick = 1'b0;
            end else if (hold_q == HW'(MAX_HOLD) && |others) begin
                preempt  = 1'b1;
                pick_req = others;
                pick_ptr = nxt(owner_q);
            end else begin
                use_pick = 1'b0;
                own_gnt  = 1'b1;
            end
        end
        gnt = '0;
        if (!reset) begin
            if (use_pick)     gnt = win_oh;
            else if (own_gnt) gnt = NREQ'(1) << owner_q;
        end
        gnt_any = |gnt;
        gnt_idx = use_pick ? win_idx : owner_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
        end else if (gnt_any) begin
            owner_q <= gnt_idx;
            if (state_q == ARB || preempt) begin
                ptr_q <= nxt(gnt_idx);
                if (lock[gnt_idx]) begin
                    state_q <= LOCK;
                    hold_q  <= HW'(1);
                end else begin
                    state_q <= ARB;
                    hold_q  <= '0;
                end
            end else if (lock[gnt_idx]) begin
                if (hold_q != HW'(MAX_HOLD)) hold_q <= hold_q + 1'b1;
            end else begin
                state_q <= ARB;
                hold_q  <= '0;
            end
        end else if (state_q == LOCK) begin
            state_q <= ARB;
            hold_q  <= '0;
        end
    end

    logic            res_rd_q;
    logic            res_wr_q;
    logic [AW-1:0]   res_addr_q;
    logic [DW-1:0]   res_do_q;
    logic [IW-1:0]   tag_q;
    logic [NREQ-1:0] rvalid_q;
    logic [DW-1:0]   rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            tag_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            res_rd_q <= gnt_any && !we[gnt_idx];
            res_wr_q <= gnt_any &&  we[gnt_idx];
            if (gnt_any) begin
                res_addr_q <= addr[32'(gnt_idx) * AW +: AW];
                res_do_q   <= wdata[32'(gnt_idx) * DW +: DW];
                tag_q      <= gnt_idx;
            end
            rvalid_q <= res_rd_q ? (NREQ'(1) << tag_q) : '0;
            if (res_rd_q) rdata_q <= res_di;
        end
    end

    assign owner    = owner_q;
    assign res_rd   = res_rd_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule
